// File: rtl/ula_pkg.sv
// Shared definitions for the ULA port-FE block: read-data bit positions,
// default port decode and the layout of the byte written to port FE.
package ula_pkg;

    localparam int KEY_LSB    = 0;
    localparam int EAR_IN_BIT = 6;

    localparam logic [15:0] DEFAULT_PORT_MASK  = 16'h0001;
    localparam logic [15:0] DEFAULT_PORT_MATCH = 16'h0000;

    typedef struct packed {
        logic [2:0] unused;
        logic       ear;
        logic       mic;
        logic [2:0] border;
    } port_fe_t;

endpackage

// File: rtl/ula_port_io_if.sv
// CPU-side I/O bus seen by the ULA port block: address, write data, write
// strobe and the combinational read data returned for port FE.
interface ula_port_io_if;

    logic [15:0] A;
    logic [7:0]  D;
    logic        io_we;
    logic [7:0]  ula_data;

    modport master (output A, D, io_we, input ula_data);
    modport slave  (input A, D, io_we, output ula_data);

endinterface

// File: rtl/sigma_delta_dac.sv
// First-order 1-bit sigma-delta modulator: the density of ones on bit_out
// equals sample / 2^DAC_W.
module sigma_delta_dac #(
    parameter int DAC_W = 8
) (
    input  logic             clk_cpu,
    input  logic             nreset,
    input  logic [DAC_W-1:0] sample,
    output logic             bit_out
);

    // The accumulator carry is held in bit_out, so only the low bits are stored.
    logic [DAC_W-1:0] acc;
    logic [DAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, sample};

    always_ff @(posedge clk_cpu) begin
        if (!nreset) begin
            acc     <= '0;
            bit_out <= 1'b0;
        end else begin
            acc     <= acc_sum[DAC_W-1:0];
            bit_out <= acc_sum[DAC_W];
        end
    end

endmodule

// File: rtl/ula_port_io.sv
// ULA port-FE block: port decode and read mux, border/EAR/MIC latch, filtered
// tape input, sigma-delta audio mix and beeper activity LED.
module ula_port_io
    import ula_pkg::*;
#(
    parameter logic [15:0] PORT_MASK   = DEFAULT_PORT_MASK,
    parameter logic [15:0] PORT_MATCH  = DEFAULT_PORT_MATCH,
    parameter int          FILT_LEN    = 4,
    parameter int          DAC_W       = 8,
    parameter int          EAR_WEIGHT  = 128,
    parameter int          MIC_WEIGHT  = 32,
    parameter int          TAPE_WEIGHT = 64,
    parameter int          LED_DIV_W   = 7,
    parameter int          ISSUE       = 3
) (
    input  logic         clk_cpu,
    input  logic         nreset,
    ula_port_io_if.slave bus,
    input  logic [4:0]   key_row,
    input  logic         AUD_IN,
    output logic [2:0]   border,
    output logic         ear,
    output logic         mic,
    output logic         tape_in,
    output logic         tape_edge,
    output logic         AUD_OUT,
    output logic         beeper
);

    localparam int               CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);
    localparam logic [DAC_W+1:0] EAR_W    = (DAC_W + 2)'(EAR_WEIGHT);
    localparam logic [DAC_W+1:0] MIC_W    = (DAC_W + 2)'(MIC_WEIGHT);
    localparam logic [DAC_W+1:0] TAPE_W   = (DAC_W + 2)'(TAPE_WEIGHT);

    function automatic logic [DAC_W-1:0] sat_sample(input logic [DAC_W+1:0] s);
        return (s[DAC_W+1:DAC_W] != 2'b00) ? {DAC_W{1'b1}} : s[DAC_W-1:0];
    endfunction

    logic       port_hit;
    port_fe_t   fe;
    logic [2:0] fe_unused;
    logic       ear_in;

    assign port_hit  = ((bus.A & PORT_MASK) == PORT_MATCH);
    assign fe        = port_fe_t'(bus.D);
    assign fe_unused = fe.unused;

    // Issue 2 boards also leak MIC onto the EAR input bit.
    always_comb begin
        ear_in = tape_in | ear;
        if (ISSUE == 2) begin
            ear_in = ear_in | mic;
        end
        bus.ula_data = 8'hFF;
        if (port_hit) begin
            bus.ula_data[EAR_IN_BIT]   = ear_in;
            bus.ula_data[KEY_LSB +: 5] = key_row;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (!nreset) begin
            border <= 3'd0;
            ear    <= 1'b0;
            mic    <= 1'b0;
        end else if (bus.io_we && port_hit) begin
            border <= fe.border;
            mic    <= fe.mic;
            ear    <= fe.ear;
        end
    end

    logic             tape_sync_p0;
    logic             tape_sync_p1;
    logic [CNT_W-1:0] filt_cnt;

    // Tape level only follows the synchronised input once it has disagreed for FILT_LEN cycles in a row.
    always_ff @(posedge clk_cpu) begin
        if (!nreset) begin
            tape_sync_p0 <= 1'b0;
            tape_sync_p1 <= 1'b0;
            filt_cnt     <= '0;
            tape_in      <= 1'b0;
            tape_edge    <= 1'b0;
        end else begin
            tape_sync_p0 <= AUD_IN;
            tape_sync_p1 <= tape_sync_p0;
            tape_edge    <= 1'b0;
            if (tape_sync_p1 != tape_in) begin
                if (filt_cnt == CNT_LAST) begin
                    tape_in   <= tape_sync_p1;
                    filt_cnt  <= '0;
                    tape_edge <= 1'b1;
                end else begin
                    filt_cnt <= filt_cnt + CNT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    logic [DAC_W+1:0] mix_sum;

    assign mix_sum = (ear     ? EAR_W  : '0)
                   + (mic     ? MIC_W  : '0)
                   + (tape_in ? TAPE_W : '0);

    sigma_delta_dac #(
        .DAC_W(DAC_W)
    ) u_dac (
        .clk_cpu (clk_cpu),
        .nreset  (nreset),
        .sample  (sat_sample(mix_sum)),
        .bit_out (AUD_OUT)
    );

    logic                 ear_prev;
    logic [LED_DIV_W-1:0] led_cnt;

    // Counter starts at all ones, so the first toggle lands on the 2^LED_DIV_W-th EAR rise.
    always_ff @(posedge clk_cpu) begin
        if (!nreset) begin
            ear_prev <= 1'b0;
            led_cnt  <= '1;
            beeper   <= 1'b0;
        end else begin
            ear_prev <= ear;
            if (ear && !ear_prev) begin
                if (led_cnt == '0) begin
                    beeper <= ~beeper;
                end
                led_cnt <= led_cnt - LED_DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ula_port_io.sv
// Bench for ula_port_io: an issue-3 default build and an issue-2 build with
// heavy EAR/MIC weights, both driven from the same bus and checked against a model.
module tb_ula_port_io;

    localparam int FILT = 4;
    localparam int LED_EDGES = 128;

    logic clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    logic       nreset;
    logic [4:0] key_row;
    logic       AUD_IN;

    ula_port_io_if bus3();
    ula_port_io_if bus2();

    assign bus2.A     = bus3.A;
    assign bus2.D     = bus3.D;
    assign bus2.io_we = bus3.io_we;

    logic [2:0] border3, border2;
    logic       ear3, ear2, mic3, mic2, tape3, tape2, edge3, edge2;
    logic       aud3, aud2, beep3, beep2;

    ula_port_io dut3 (
        .clk_cpu (clk_cpu), .nreset (nreset), .bus (bus3), .key_row (key_row),
        .AUD_IN (AUD_IN), .border (border3), .ear (ear3), .mic (mic3),
        .tape_in (tape3), .tape_edge (edge3), .AUD_OUT (aud3), .beeper (beep3)
    );

    ula_port_io #(
        .EAR_WEIGHT (200), .MIC_WEIGHT (100), .ISSUE (2)
    ) dut2 (
        .clk_cpu (clk_cpu), .nreset (nreset), .bus (bus2), .key_row (key_row),
        .AUD_IN (AUD_IN), .border (border2), .ear (ear2), .mic (mic2),
        .tape_in (tape2), .tape_edge (edge2), .AUD_OUT (aud2), .beeper (beep2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [2:0] m_border;
    logic       m_ear, m_mic, m_tape, m_edge, m_ear_prev;
    int         rises;
    logic       aud_q[$];
    logic       s_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_border = 3'd0; m_ear = 1'b0; m_mic = 1'b0; m_tape = 1'b0; m_edge = 1'b0;
        m_ear_prev = 1'b0; rises = 0;
        aud_q.delete(); aud_q.push_back(1'b0); aud_q.push_back(1'b0);
        s_hist.delete();
    endtask

    task automatic tick();
        logic        c_rst, c_we, c_aud, s, flip;
        logic [15:0] c_a;
        logic [7:0]  c_d;
        c_rst = nreset; c_we = bus3.io_we; c_aud = AUD_IN; c_a = bus3.A; c_d = bus3.D;
        @(posedge clk_cpu);
        #1;
        cyc++;
        if (!c_rst) begin
            model_reset();
        end else begin
            // tape level flips once the last FILT synchronised samples all disagree with it
            s = aud_q.pop_front();
            aud_q.push_back(c_aud);
            s_hist.push_back(s);
            if (s_hist.size() > FILT) void'(s_hist.pop_front());
            flip = (s_hist.size() == FILT);
            foreach (s_hist[i]) if (s_hist[i] == m_tape) flip = 1'b0;
            m_edge = flip;
            if (flip) m_tape = ~m_tape;
            if (m_ear && !m_ear_prev) rises++;
            m_ear_prev = m_ear;
            if (c_we && ((c_a & 16'h0001) == 16'h0000)) begin
                m_border = c_d[2:0]; m_mic = c_d[3]; m_ear = c_d[4];
            end
        end
    endtask

    function automatic logic [7:0] exp_data(input int issue);
        logic b6;
        if ((bus3.A & 16'h0001) != 16'h0000) return 8'hFF;
        b6 = m_tape | m_ear | ((issue == 2) ? m_mic : 1'b0);
        return {1'b1, b6, 1'b1, key_row};
    endfunction

    function automatic int exp_sample(input int ew, input int mw);
        int s;
        s = (m_ear ? ew : 0) + (m_mic ? mw : 0) + (m_tape ? 64 : 0);
        return (s > 255) ? 255 : s;
    endfunction

    task automatic check_all();
        int expb;
        expb = (rises / LED_EDGES) % 2;
        chk("border3", 32'(border3), 32'(m_border));
        chk("border2", 32'(border2), 32'(m_border));
        chk("ear3", 32'(ear3), 32'(m_ear));
        chk("ear2", 32'(ear2), 32'(m_ear));
        chk("mic3", 32'(mic3), 32'(m_mic));
        chk("mic2", 32'(mic2), 32'(m_mic));
        chk("tape_in3", 32'(tape3), 32'(m_tape));
        chk("tape_in2", 32'(tape2), 32'(m_tape));
        chk("tape_edge3", 32'(edge3), 32'(m_edge));
        chk("tape_edge2", 32'(edge2), 32'(m_edge));
        chk("beeper3", 32'(beep3), 32'(expb));
        chk("beeper2", 32'(beep2), 32'(expb));
        chk("ula_data3", 32'(bus3.ula_data), 32'(exp_data(3)));
        chk("ula_data2", 32'(bus2.ula_data), 32'(exp_data(2)));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all();
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus3.A = a; bus3.D = d; bus3.io_we = 1'b1;
        tick();
        bus3.io_we = 1'b0;
        check_all();
    endtask

    task automatic dac_window(input string name);
        int ones3, ones2, e3, e2;
        step(2);
        e3 = exp_sample(128, 32);
        e2 = exp_sample(200, 100);
        ones3 = 0; ones2 = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            check_all();
            ones3 += int'(aud3);
            ones2 += int'(aud2);
        end
        chk({name, "_ones3"}, 32'(ones3), 32'(e3));
        chk({name, "_ones2"}, 32'(ones2), 32'(e2));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic [4:0]  key;
        logic [2:0]  border;
        logic        ear;
        logic        mic;
        logic [7:0]  data3;
        logic [7:0]  data2;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, edges, tog3, tog2;
        logic pb3, pb2;

        vt[0] = '{16'h00FE, 8'h15, 1'b1, 5'h1E, 3'd5, 1'b1, 1'b0, 8'hFE, 8'hFE};
        vt[1] = '{16'hFEFE, 8'h00, 1'b0, 5'h1E, 3'd5, 1'b1, 1'b0, 8'hFE, 8'hFE};
        vt[2] = '{16'h00FF, 8'h07, 1'b1, 5'h1E, 3'd5, 1'b1, 1'b0, 8'hFF, 8'hFF};
        vt[3] = '{16'h7FFE, 8'h08, 1'b1, 5'h0F, 3'd0, 1'b0, 1'b1, 8'hAF, 8'hEF};
        vt[4] = '{16'h0001, 8'h1F, 1'b1, 5'h00, 3'd0, 1'b0, 1'b1, 8'hFF, 8'hFF};
        vt[5] = '{16'h1234, 8'hE2, 1'b0, 5'h15, 3'd0, 1'b0, 1'b1, 8'hB5, 8'hF5};
        vt[6] = '{16'h1234, 8'hE2, 1'b1, 5'h15, 3'd2, 1'b0, 1'b0, 8'hB5, 8'hB5};
        vt[7] = '{16'hFFFE, 8'h1B, 1'b1, 5'h1F, 3'd3, 1'b1, 1'b1, 8'hFF, 8'hFF};

        nreset = 1'b0; key_row = 5'h1F; AUD_IN = 1'b0;
        bus3.A = 16'hFFFF; bus3.D = 8'h00; bus3.io_we = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_border", 32'(border3), 32'd0);
        chk("rst_ear", 32'(ear3), 32'd0);
        chk("rst_mic", 32'(mic3), 32'd0);
        chk("rst_tape_in", 32'(tape3), 32'd0);
        chk("rst_aud_out3", 32'(aud3), 32'd0);
        chk("rst_aud_out2", 32'(aud2), 32'd0);
        chk("rst_beeper", 32'(beep3), 32'd0);
        check_all();
        nreset = 1'b1;

        // Decode and write table
        for (int i = 0; i < 8; i++) begin
            bus3.A = vt[i].a; bus3.D = vt[i].d; bus3.io_we = vt[i].we; key_row = vt[i].key;
            tick();
            chk($sformatf("vec%0d_border", i), 32'(border3), 32'(vt[i].border));
            chk($sformatf("vec%0d_ear", i), 32'(ear3), 32'(vt[i].ear));
            chk($sformatf("vec%0d_mic", i), 32'(mic3), 32'(vt[i].mic));
            chk($sformatf("vec%0d_data3", i), 32'(bus3.ula_data), 32'(vt[i].data3));
            chk($sformatf("vec%0d_data2", i), 32'(bus2.ula_data), 32'(vt[i].data2));
            check_all();
        end
        bus3.io_we = 1'b0;

        // Tape step latency and single-cycle edge pulse
        AUD_IN = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            check_all();
            if (tape3) begin
                lat = i;
                chk("tape_edge_on_change", 32'(edge3), 32'd1);
            end
        end
        chk("tape_latency", 32'(lat), 32'(2 + FILT));
        tick();
        check_all();
        chk("tape_edge_one_cycle", 32'(edge3), 32'd0);

        // Three-cycle glitch is rejected
        AUD_IN = 1'b0;
        step(3);
        AUD_IN = 1'b1;
        edges = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_all();
            edges += int'(edge3) + int'(edge2);
        end
        chk("glitch_tape_in", 32'(tape3), 32'd1);
        chk("glitch_edges", 32'(edges), 32'd0);

        // DAC densities
        AUD_IN = 1'b0;
        step(8);
        wr(16'h00FE, 8'h10);
        dac_window("dac_ear");
        wr(16'h00FE, 8'h08);
        dac_window("dac_mic");
        wr(16'h00FE, 8'h18);
        AUD_IN = 1'b1;
        step(8);
        dac_window("dac_all");

        // Reset in the middle of DAC activity and a filter count
        AUD_IN = 1'b0;
        step(3);
        nreset = 1'b0;
        AUD_IN = 1'b1;
        tick();
        chk("mid_rst_border", 32'(border3), 32'd0);
        chk("mid_rst_ear", 32'(ear3), 32'd0);
        chk("mid_rst_mic", 32'(mic2), 32'd0);
        chk("mid_rst_tape_in", 32'(tape3), 32'd0);
        chk("mid_rst_tape_edge", 32'(edge3), 32'd0);
        chk("mid_rst_aud_out3", 32'(aud3), 32'd0);
        chk("mid_rst_aud_out2", 32'(aud2), 32'd0);
        chk("mid_rst_beeper", 32'(beep2), 32'd0);
        check_all();
        nreset = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            check_all();
            if (tape3) lat = i;
        end
        chk("tape_latency_after_rst", 32'(lat), 32'(2 + FILT));

        // Beeper divider over 256 EAR rising edges
        tog3 = 0; tog2 = 0; pb3 = beep3; pb2 = beep2;
        for (int e = 1; e <= 256; e++) begin
            wr(16'h00FE, 8'h10);
            wr(16'h00FE, 8'h00);
            if (beep3 != pb3) tog3++;
            if (beep2 != pb2) tog2++;
            pb3 = beep3; pb2 = beep2;
            if (e == 127) chk("beeper_toggles_127", 32'(tog3), 32'd0);
            if (e == 128) chk("beeper_toggles_128", 32'(tog3), 32'd1);
        end
        chk("beeper_toggles_256_3", 32'(tog3), 32'd2);
        chk("beeper_toggles_256_2", 32'(tog2), 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            nreset      = ($urandom_range(0, 299) != 0);
            bus3.A      = 16'($urandom());
            bus3.D      = 8'($urandom());
            bus3.io_we  = ($urandom_range(0, 2) == 0);
            key_row     = 5'($urandom());
            if ($urandom_range(0, 4) == 0) AUD_IN = ~AUD_IN;
            tick();
            check_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
